// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronised row sampling,
// first-key-wins scan, debounce and commit. KEYPAD_REPEAT_EN adds auto-repeat pulses.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press
);

  localparam int            TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]    DB_MAX    = 4'(DEBOUNCE_SCANS);
  // nibble {r,c} holds the hex value of the key at row r, column c
  localparam logic [63:0]   KEY_LUT   = 64'hDEF0_C987_B654_A321;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } scan_res_t;

  localparam scan_res_t NONE = 5'b0_0000;

  if (SCAN_TICKS < 2 || SCAN_TICKS > (1 << 20) || DEBOUNCE_SCANS < 1 ||
      DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]    row_s1, row_s2;
  logic [TW-1:0] tick;
  logic [1:0]    col_idx;
  logic [3:0]    stable_cnt;
  logic          scan_end_q;
  scan_res_t     acc, prev, committed;
  scan_res_t     cur_hit, scan_res;
  logic [3:0]    row_low;
  logic [1:0]    low_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW       = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep_cnt;
`endif

  // lowest-index low row in the column currently being driven
  always_comb begin
    row_low = ~row_s2;
    low_idx = 2'd0;
    for (int r = 3; r >= 0; r--)
      if (row_low[r]) low_idx = 2'(r);
    cur_hit.vld  = |row_low;
    cur_hit.code = (|row_low) ? KEY_LUT[{low_idx, col_idx, 2'b00} +: 4] : 4'h0;
    scan_res     = acc.vld ? acc : cur_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      tick       <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      acc        <= NONE;
      prev       <= NONE;
      committed  <= NONE;
      stable_cnt <= 4'd0;
      scan_end_q <= 1'b0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_press  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      row_s1     <= row;
      row_s2     <= row_s1;
      key_press  <= 1'b0;
      scan_end_q <= 1'b0;

      if (tick == LAST_TICK) begin
        tick    <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (col_idx == 2'd3) begin
          stable_cnt <= (scan_res == prev) ?
                        ((stable_cnt == DB_MAX) ? DB_MAX : 4'(stable_cnt + 4'd1)) : 4'd1;
          prev       <= scan_res;
          acc        <= NONE;
          scan_end_q <= 1'b1;
        end else if (!acc.vld) begin
          acc <= cur_hit;
        end
      end else begin
        tick <= tick + 1'b1;
      end

      // commit is evaluated the cycle after the debounce count settles
      if (scan_end_q) begin
        if (stable_cnt == DB_MAX && prev != committed) begin
          committed <= prev;
          key_code  <= prev.code;
          key_valid <= prev.vld;
          key_press <= prev.vld;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt   <= '0;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        else if (committed.vld) begin
          if (rep_cnt == REP_LAST) begin
            rep_cnt   <= '0;
            key_press <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_TICKS, default 100000, giving the clock cycles each column is driven before its rows are sampled (legal range 2 to 2^20).
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4, giving the consecutive identical full-scan results required to commit a key (legal range 1 to 15).
REQ-003 The block SHALL have parameter REPEAT_SCANS, default 200, giving the full scans between repeat pulses (used only with KEYPAD_REPEAT_EN).
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 The block SHALL have port col, output, 4 bits: keypad column drive, active-low, one-cold.
REQ-008 The block SHALL have port key_code, output, 4 bits: committed key hex value; this is the playerB code consumed by chara_control.
REQ-009 The block SHALL have port key_valid, output, 1 bit: high while a committed key is held.
REQ-010 The block SHALL have port key_press, output, 1 bit: one-cycle pulse per key event.

Function
REQ-011 The block SHALL double-flop row into clk before any use.
REQ-012 The block SHALL drive exactly one col bit low, cycling col index 0,1,2,3,0 and so on, and SHALL hold each index for SCAN_TICKS cycles.
REQ-013 The block SHALL sample the synchronised row on the last cycle of each dwell, before col advances.
REQ-014 The block SHALL map keys (row r, col c) as follows: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-015 The block SHALL take the first low row found within a full scan as the scan result, with lower col index first and then lower row index; all later keys in that scan SHALL be ignored.
REQ-016 A scan with no low row SHALL yield the result NONE.
REQ-017 At the end of each col-3 sample, the block SHALL increment stable_cnt if the scan result equals the previous result, saturating at DEBOUNCE_SCANS; otherwise it SHALL set stable_cnt to 1.
REQ-018 When stable_cnt reaches DEBOUNCE_SCANS and the result differs from the committed value, the block SHALL commit the result on the next clk edge.
REQ-019 On commit of key K: key_code = K, key_valid = 1, and key_press SHALL pulse high for exactly 1 cycle.
REQ-020 On commit of NONE: key_code = 4'h0, key_valid = 0, and key_press SHALL not pulse.
REQ-021 A direct key-to-key change SHALL commit the new key and pulse key_press once; NONE SHALL not be committed in between.
REQ-022 Worst-case latency from a stable press to key_valid SHALL be at most (DEBOUNCE_SCANS+1) x 4 x SCAN_TICKS + 3 cycles.
REQ-023 A bounce shorter than one full scan SHALL never change key_code.
REQ-024 key_code SHALL change only at commit instants and SHALL be stable between them.

Reset
REQ-025 While rst is high, the block SHALL set col = 4'b1110, col index and dwell counter to 0, stable_cnt to 0, previous and committed results to NONE, key_code = 4'h0, key_valid = 0, and key_press = 0.
REQ-026 rst asserted mid-dwell or mid-debounce SHALL discard all partial state; the first sample after reset release SHALL occur SCAN_TICKS cycles later on col 0.

Configuration
REQ-027 The block SHALL use the macro KEYPAD_REPEAT_EN.
REQ-028 With KEYPAD_REPEAT_EN defined, while a key stays committed the block SHALL pulse key_press once every REPEAT_SCANS completed full scans after the commit pulse; the repeat counter SHALL clear on any commit or reset.
REQ-029 Without KEYPAD_REPEAT_EN, key_press SHALL pulse only on commit of a key, and the repeat counter SHALL be absent.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=2; one full scan = 16 cycles)
REQ-030 Scenario: hold "5" (row1 low while col1 is driven) from reset release -> key_valid rises and key_code = 4'h5 within 67 cycles, with exactly one key_press pulse.
REQ-031 Scenario: press "8" for 10 cycles, then release -> key_code stays 4'h0, key_valid stays 0, and key_press never pulses.
REQ-032 Scenario: hold "2" and "6" together -> key_code = 4'h2.
REQ-033 Scenario: commit "4", then switch directly to "6" -> key_code goes 4 then 6 with no 4'h0 gap, and key_press pulses twice in total.
REQ-034 Scenario: assert rst for 1 cycle while "5" is committed -> the next cycle shows col = 4'b1110, key_valid = 0, and key_code = 4'h0; with "5" still held, re-commit occurs within 67 cycles.
REQ-035 Scenario: with KEYPAD_REPEAT_EN defined, hold "8" for 200 cycles -> key_press pulses at commit and then every 32 cycles; without the macro -> exactly one pulse.
